// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM states, opcodes and
// the encodings of every datapath select and ALU operation it drives.
// Ports: none (package).
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] ASEL_PC    = 2'b00;
  localparam logic [1:0] ASEL_OLDPC = 2'b01;
  localparam logic [1:0] ASEL_RS1   = 2'b10;

  localparam logic [1:0] BSEL_RS2  = 2'b00;
  localparam logic [1:0] BSEL_IMM  = 2'b01;
  localparam logic [1:0] BSEL_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// Purpose: map opcode/funct3/funct7b5 to an ALU operation; flags shift funct3.
// Latency: purely combinational.
// Backpressure: none.
// Ports: opcode_i/funct3_i/funct7b5_i instruction fields in;
//        alu_control_o operation, illegal_o unsupported R/I funct3.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o,
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    if (opcode_i == OP_BRANCH) begin
      alu_control_o = ALU_SUB;
    end else if (opcode_i == OP_RTYPE || opcode_i == OP_ITYPE) begin
      case (funct3_i)
        // funct7b5 only selects sub for register-register ops; for I-type
        // that bit belongs to the immediate.
        3'b000:  alu_control_o = (opcode_i == OP_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_control_o = ALU_SLT;
        3'b011:  alu_control_o = ALU_SLTU;
        3'b100:  alu_control_o = ALU_XOR;
        3'b110:  alu_control_o = ALU_OR;
        3'b111:  alu_control_o = ALU_AND;
        default: illegal_o     = 1'b1;  // shifts have no ALU support
      endcase
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Purpose: multi-cycle CPU control FSM with memory wait counting and abort.
// Latency: zero-wait lw 5, sw/R/I/jal 4, branch 3, illegal 2 cycles.
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE until mem_ready, aborts to FETCH after WAIT_MAX waits.
// Ports: clk, reset (sync, active-low); instruction, N/Z/C/V flags, mem_ready in;
//        memory/strobe/select/ALU control outputs, mem_timeout and illegal_instr pulses out.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        N,
  input  logic        Z,
  input  logic        C,
  input  logic        V,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        dmem_wren,
  output logic        adr_sel,
  output logic        pc_wren,
  output logic        ir_wren,
  output logic        regfile_wren,
  output logic [1:0]  ALU_asel,
  output logic [1:0]  ALU_bsel,
  output logic [1:0]  result_sel,
  output logic [1:0]  ximm_sel,
  output logic [2:0]  ALU_control,
  output logic        mem_timeout,
  output logic        illegal_instr
);

  localparam logic [7:0] WAIT_LIM = WAIT_MAX[7:0];

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] dec_alu;
  logic       dec_ill;
  logic       wait_expired;
  logic       unused_instr_bits;

  assign opcode            = instruction[6:0];
  assign funct3            = instruction[14:12];
  assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};
  // Only meaningful while a memory access is outstanding and not completing.
  assign wait_expired      = (wait_q == WAIT_LIM) && !mem_ready;

  alu_decoder u_alu_decoder (
    .opcode_i      (opcode),
    .funct3_i      (funct3),
    .funct7b5_i    (instruction[30]),
    .alu_control_o (dec_alu),
    .illegal_o     (dec_ill)
  );

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    dmem_wren     = 1'b0;
    adr_sel       = 1'b0;
    pc_wren       = 1'b0;
    ir_wren       = 1'b0;
    regfile_wren  = 1'b0;
    ALU_asel      = ASEL_PC;
    ALU_bsel      = BSEL_RS2;
    result_sel    = RES_ALUOUT;
    ximm_sel      = IMM_I;
    ALU_control   = ALU_ADD;
    mem_timeout   = 1'b0;
    illegal_instr = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        ALU_bsel   = BSEL_FOUR;
        result_sel = RES_ALU;
        if (mem_ready) begin
          ir_wren = 1'b1;
          pc_wren = 1'b1;
          state_d = DECODE;
        end else if (wait_expired) begin
          mem_timeout = 1'b1;
        end
      end
      DECODE: begin
        // Precompute branch/jump target from old_PC while decoding.
        ALU_asel = ASEL_OLDPC;
        ALU_bsel = BSEL_IMM;
        ximm_sel = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL: begin
            ximm_sel = IMM_J;
            state_d  = JAL;
          end
          default: begin
            illegal_instr = 1'b1;
            state_d       = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALU_asel = ASEL_RS1;
        ALU_bsel = BSEL_IMM;
        ximm_sel = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d  = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_sel = 1'b1;
        if (mem_ready) begin
          state_d = MEMWB;
        end else if (wait_expired) begin
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end
      end
      MEMWB: begin
        result_sel   = RES_MEM;
        regfile_wren = 1'b1;
        state_d      = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        adr_sel   = 1'b1;
        dmem_wren = 1'b1;
        if (mem_ready) begin
          state_d = FETCH;
        end else if (wait_expired) begin
          dmem_wren   = 1'b0;
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end
      end
      EXECR, EXECI: begin
        ALU_asel      = ASEL_RS1;
        ALU_bsel      = (state_q == EXECI) ? BSEL_IMM : BSEL_RS2;
        ALU_control   = dec_alu;
        illegal_instr = dec_ill;
        state_d       = dec_ill ? FETCH : ALUWB;
      end
      ALUWB: begin
        regfile_wren = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        ALU_asel    = ASEL_RS1;
        ALU_bsel    = BSEL_RS2;
        ALU_control = ALU_SUB;
        case (funct3)
          3'b000:  pc_wren = Z;
          3'b001:  pc_wren = !Z;
          3'b100:  pc_wren = N ^ V;
          3'b101:  pc_wren = !(N ^ V);
          3'b110:  pc_wren = !C;
          3'b111:  pc_wren = C;
          default: illegal_instr = 1'b1;
        endcase
        state_d = FETCH;
      end
      JAL: begin
        ALU_asel = ASEL_OLDPC;
        ALU_bsel = BSEL_FOUR;
        pc_wren  = 1'b1;
        state_d  = ALUWB;
      end
      default: state_d = FETCH;
    endcase

    // A timeout that stays in FETCH must still restart the count.
    if (!mem_req || mem_ready || mem_timeout || state_d != state_q) begin
      wait_d = 8'd0;
    end else begin
      wait_d = wait_q + 8'd1;
    end

    if (!reset) begin
      mem_req       = 1'b0;
      dmem_wren     = 1'b0;
      adr_sel       = 1'b0;
      pc_wren       = 1'b0;
      ir_wren       = 1'b0;
      regfile_wren  = 1'b0;
      ALU_asel      = 2'b00;
      ALU_bsel      = 2'b00;
      result_sel    = 2'b00;
      ximm_sel      = 2'b00;
      ALU_control   = 3'b000;
      mem_timeout   = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: builds the expected per-cycle output trace of each
// instruction from its opcode class and memory wait pattern, and checks it.
module tb_mc_sequencer;

  localparam int WM = 3;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, dmem_wren, adr_sel, pc_wren, ir_wren, regfile_wren;
  logic [1:0]  ALU_asel, ALU_bsel, result_sel, ximm_sel;
  logic [2:0]  ALU_control;
  logic        mem_timeout, illegal_instr;

  mc_sequencer #(.WAIT_MAX(WM)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
    .mem_req(mem_req), .dmem_wren(dmem_wren), .adr_sel(adr_sel),
    .pc_wren(pc_wren), .ir_wren(ir_wren), .regfile_wren(regfile_wren),
    .ALU_asel(ALU_asel), .ALU_bsel(ALU_bsel), .result_sel(result_sel),
    .ximm_sel(ximm_sel), .ALU_control(ALU_control),
    .mem_timeout(mem_timeout), .illegal_instr(illegal_instr)
  );

  typedef logic [18:0] ovec_t;
  ovec_t obs;
  assign obs = {mem_req, dmem_wren, adr_sel, pc_wren, ir_wren, regfile_wren,
                ALU_asel, ALU_bsel, result_sel, ximm_sel, ALU_control,
                mem_timeout, illegal_instr};

  int compared = 0;
  int mismatched = 0;

  logic        cur_rst = 1'b0;
  logic [31:0] cur_ins = 32'd0;
  logic [3:0]  cur_flags = 4'd0;  // {N,Z,C,V}

  function automatic ovec_t mk(input logic req, input logic wr, input logic adr,
                               input logic pc, input logic ir, input logic rf,
                               input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] r, input logic [1:0] x,
                               input logic [2:0] alu, input logic to, input logic ill);
    return {req, wr, adr, pc, ir, rf, a, b, r, x, alu, to, ill};
  endfunction

  ovec_t F_WAIT, F_DONE, F_TO, ZERO, WB_ALU;

  // One clock cycle: drive inputs after the edge, then check the outputs.
  task automatic step(input logic mr, input ovec_t exp, input string tag);
    @(posedge clk);
    #2;
    reset       = cur_rst;
    instruction = cur_ins;
    {N, Z, C, V} = cur_flags;
    mem_ready   = mr;
    #1;
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  function automatic logic rmr();
    return 1'($urandom_range(0, 1));
  endfunction

  // Fetch with 'waits' not-ready cycles; every (WM+1)th wait is an abort.
  task automatic do_fetch(input int waits);
    int w;
    w = waits;
    while (w > WM) begin
      for (int i = 0; i < WM; i++) step(1'b0, F_WAIT, "fetch_wait");
      step(1'b0, F_TO, "fetch_timeout");
      w -= WM + 1;
    end
    for (int i = 0; i < w; i++) step(1'b0, F_WAIT, "fetch_wait");
    step(1'b1, F_DONE, "fetch_ready");
  endtask

  // Reference ALU operation for R/I instructions by funct3.
  task automatic alu_ref(input logic is_r, input logic [2:0] f3, input logic f7,
                         output logic [2:0] op, output logic ill);
    ill = 1'b0;
    case (f3)
      3'b000: op = (is_r && f7) ? 3'b001 : 3'b000;
      3'b010: op = 3'b101;
      3'b011: op = 3'b110;
      3'b100: op = 3'b100;
      3'b110: op = 3'b011;
      3'b111: op = 3'b010;
      default: begin op = 3'b000; ill = 1'b1; end
    endcase
  endtask

  // Flags of a - b and whether the branch condition holds on a, b directly.
  task automatic br_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                        output logic [3:0] fl, output logic tk);
    logic [32:0] s;
    s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
    fl = {s[31], (s[31:0] == 32'd0), s[32], (a[31] != b[31]) && (s[31] != a[31])};
    case (f3)
      3'b000:  tk = (a == b);
      3'b001:  tk = (a != b);
      3'b100:  tk = ($signed(a) < $signed(b));
      3'b101:  tk = ($signed(a) >= $signed(b));
      3'b110:  tk = (a < b);
      3'b111:  tk = (a >= b);
      default: tk = 1'b0;
    endcase
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl, input logic taken,
                           input int fw, input int mw);
    logic [6:0] op;
    logic [2:0] f3;
    logic       legal, st, ill;
    logic [2:0] aop;
    op = ins[6:0];
    f3 = ins[14:12];
    cur_ins   = ins;
    cur_flags = fl;
    do_fetch(fw);
    legal = op inside {LW, SW, RT, IT, BR, JL};
    step(rmr(), mk(0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, (op == JL) ? 2'b11 : 2'b10,
                   3'b000, 0, !legal), "decode");
    if (!legal) return;
    if (op == LW || op == SW) begin
      st = (op == SW);
      step(rmr(), mk(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, st ? 2'b01 : 2'b00, 3'b000, 0, 0), "memadr");
      for (int i = 0; i < mw && i < WM; i++)
        step(1'b0, mk(1,st,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 0), "mem_wait");
      if (mw > WM) begin
        step(1'b0, mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1, 0), "mem_timeout");
        return;
      end
      step(1'b1, mk(1,st,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 0), "mem_ready");
      if (!st) step(rmr(), mk(0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 3'b000, 0, 0), "memwb");
    end else if (op == RT || op == IT) begin
      alu_ref(op == RT, f3, ins[30], aop, ill);
      step(rmr(), mk(0,0,0,0,0,0, 2'b10, (op == RT) ? 2'b00 : 2'b01, 2'b00, 2'b00, aop, 0, ill), "exec");
      if (!ill) step(rmr(), WB_ALU, "aluwb");
    end else if (op == BR) begin
      ill = (f3 == 3'b010) || (f3 == 3'b011);
      step(rmr(), mk(0,0,0,taken,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b001, 0, ill), "branch");
    end else begin
      step(rmr(), mk(0,0,0,1,0,0, 2'b01,2'b10,2'b00,2'b00, 3'b000, 0, 0), "jal");
      step(rmr(), WB_ALU, "jal_wb");
    end
  endtask

  initial begin
    logic [31:0] ins, a, b;
    logic [3:0]  fl;
    logic        tk;
    int          kind;

    F_WAIT = mk(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0, 0);
    F_DONE = mk(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0, 0);
    F_TO   = mk(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 1, 0);
    ZERO   = '0;
    WB_ALU = mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 0);

    // Reset holds every output low.
    cur_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur_ins = $urandom;
      step(rmr(), ZERO, "reset_outputs");
    end
    cur_rst = 1'b1;

    // lw with zero waits, then sw with three not-ready cycles.
    run_instr({$urandom_range(0, 33554431), LW} & 32'hFFFF_FFFF, 4'd0, 1'b0, 0, 0);
    run_instr({25'h0AB_CDE, SW}, 4'd0, 1'b0, 0, 3);

    // blt: N=1,V=0 taken; N=1,V=1 not taken.
    run_instr({17'h0, 3'b100, 5'h0, BR}, 4'b1000, 1'b1, 0, 0);
    run_instr({17'h0, 3'b100, 5'h0, BR}, 4'b1001, 1'b0, 0, 0);

    // Fetch stuck for two full timeouts before completing.
    run_instr({1'b0, 1'b1, 13'h0, 3'b000, 5'h0, RT}, 4'd0, 1'b0, 8, 0);

    // Unsupported opcode (lui).
    run_instr({25'h1234, 7'b0110111}, 4'd0, 1'b0, 0, 0);

    // Reset while a store is stalled abandons it; next fetch starts with a fresh count.
    cur_ins = {25'h0, SW};
    do_fetch(0);
    step(rmr(), mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 0, 0), "decode");
    step(rmr(), mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01, 3'b000, 0, 0), "memadr");
    step(1'b0, mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0, 0), "mem_wait");
    cur_rst = 1'b0;
    step(1'b0, ZERO, "reset_in_memwrite");
    cur_rst = 1'b1;
    run_instr({25'h0, JL}, 4'd0, 1'b0, WM, 0);

    // Randomized instruction mix.
    for (int n = 0; n < 80; n++) begin
      ins  = $urandom;
      kind = $urandom_range(0, 6);
      fl   = 4'($urandom);
      tk   = 1'b0;
      case (kind)
        0: ins[6:0] = LW;
        1: ins[6:0] = SW;
        2: ins[6:0] = RT;
        3: ins[6:0] = IT;
        4: begin
          ins[6:0] = BR;
          a = $urandom;
          b = ($urandom_range(0, 3) == 0) ? a : $urandom;
          br_ref(a, b, ins[14:12], fl, tk);
        end
        5: ins[6:0] = JL;
        default: while (ins[6:0] inside {LW, SW, RT, IT, BR, JL}) ins[6:0] = 7'($urandom);
      endcase
      run_instr(ins, fl, tk,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 0,
                $urandom_range(0, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
